// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : 8n1 UART receiver with 8x oversampling, 3-sample majority vote
//               and a one-entry valid/ready output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] data,
    output logic       frame_err,
    output logic       overrun
);

    localparam int c_div_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_sync1;
    logic               r_rx_s;
    logic               r_rx_d;
    logic [c_div_w-1:0] r_div;
    logic [2:0]         r_s;
    logic [2:0]         r_smp;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;

    logic               w_tick;
    logic               w_start;
    logic               w_smp2;
    logic               w_vote;

    assign w_tick  = (r_div == c_div_last);
    // Requiring rx_d high means a held-low break cannot retrigger a frame.
    assign w_start = (r_state == S_IDLE) && r_rx_d && !r_rx_s;

    // The stop decision is taken on the s==5 tick, so the third sample is
    // used directly from the line rather than from its capture register.
    assign w_smp2  = (r_s == 3'd5) ? r_rx_s : r_smp[2];
    assign w_vote  = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_smp2) | (r_smp[1] & w_smp2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_s       <= 3'd0;
            r_smp     <= 3'b000;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            valid     <= 1'b0;
            data      <= 8'h00;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if (w_start || w_tick) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (w_start) begin
                r_s <= 3'd0;
            end else if (w_tick) begin
                r_s <= r_s + 3'd1;
            end

            if (w_tick) begin
                case (r_s)
                    3'd3:    r_smp[0] <= r_rx_s;
                    3'd4:    r_smp[1] <= r_rx_s;
                    3'd5:    r_smp[2] <= r_rx_s;
                    default: ;
                endcase
            end

            // Pop; a delivery in the same cycle below overrides this.
            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_START;
                        r_bit_cnt <= 3'd0;
                    end
                end
                S_START: begin
                    if (w_tick && r_s == 3'd7) begin
                        r_state <= w_vote ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick && r_s == 3'd7) begin
                        r_shift   <= {w_vote, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    // Deciding mid stop bit leaves half a bit to catch the next start edge.
                    if (w_tick && r_s == 3'd5) begin
                        r_state <= S_IDLE;
                        if (!w_vote) begin
                            frame_err <= 1'b1;
                        end else if (!valid || ready) begin
                            data  <= r_shift;
                            valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Directed self-checking bench for uart_rx_ctrl (DIV=4, 32 clk/bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int c_div = 4;
    localparam int c_bit = 8 * c_div;

    logic       clk;
    logic       rst;
    logic       uart_rx;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       frame_err;
    logic       overrun;

    int n_cmp;
    int n_bad;
    int pop_cnt;
    int fe_cnt;
    int ov_cnt;
    logic [7:0] last_pop;
    logic prev_valid;
    time  t_start;
    time  t_rise;

    uart_rx_ctrl #(.DIV(c_div)) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .valid     (valid),
        .ready     (ready),
        .data      (data),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observer: samples on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (valid && ready) begin
            pop_cnt  = pop_cnt + 1;
            last_pop = data;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (overrun)   ov_cnt = ov_cnt + 1;
        if (valid && !prev_valid) t_rise = $time;
        prev_valid = valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            uart_rx = 1'b1;
        end
    endtask

    // Drives start + 8 data bits (LSB first) + stop; spike inverts c=20..23 of each data bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic spike);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < c_bit; c++) begin
                @(negedge clk);
                uart_rx = bits[i] ^ (spike && i >= 1 && i <= 8 && c >= 20 && c <= 23);
                if (i == 0 && c == 0) t_start = $time;
            end
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 ready = v;
    endtask

    initial begin
        int pops0;
        int fe0;
        int ov0;
        int lat;
        n_cmp = 0; n_bad = 0; pop_cnt = 0; fe_cnt = 0; ov_cnt = 0;
        last_pop = 8'h00; prev_valid = 1'b0; t_start = 0; t_rise = 0;
        rst = 1'b1; uart_rx = 1'b1; ready = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        idle(40);

        // Basic byte with ready held high.
        set_ready(1'b1);
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(64);
        lat = int'((t_rise - t_start) / 10);
        check("a5_pops", pop_cnt, 1);
        check("a5_data", {24'd0, last_pop}, 32'hA5);
        check("a5_latency_ok", {31'd0, (lat >= 314 && lat <= 316)}, 32'd1);
        check("a5_no_fe", fe_cnt, 0);

        // Back-to-back frames into a full buffer.
        set_ready(1'b0);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(64);
        check("b2b_valid_held", {31'd0, valid}, 32'd1);
        check("b2b_data_held", {24'd0, data}, 32'h00);
        check("b2b_overrun", ov_cnt, 1);
        check("b2b_no_fe", fe_cnt, 0);
        set_ready(1'b1);
        idle(4);
        check("b2b_pops", pop_cnt, 2);
        check("b2b_pop_data", {24'd0, last_pop}, 32'h00);
        check("b2b_valid_clr", {31'd0, valid}, 32'd0);

        // Bad stop bit, then a good frame.
        pops0 = pop_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(2 * c_bit);
        check("fe_pulse", fe_cnt, 1);
        check("fe_no_pop", pop_cnt, pops0);
        check("fe_valid", {31'd0, valid}, 32'd0);
        send_frame(8'h55, 1'b1, 1'b0);
        idle(64);
        check("after_fe_pops", pop_cnt, pops0 + 1);
        check("after_fe_data", {24'd0, last_pop}, 32'h55);

        // Short glitch on idle line must be rejected.
        pops0 = pop_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
        repeat (6) begin
            @(negedge clk);
            uart_rx = 1'b0;
        end
        idle(12 * c_bit);
        check("glitch_no_pop", pop_cnt, pops0);
        check("glitch_no_fe", fe_cnt, fe0);
        check("glitch_no_ov", ov_cnt, ov0);

        // Mid-sample spikes outvoted.
        send_frame(8'h96, 1'b1, 1'b1);
        idle(64);
        check("spike_pops", pop_cnt, pops0 + 1);
        check("spike_data", {24'd0, last_pop}, 32'h96);

        // Reset mid-frame with a byte sitting in the buffer.
        set_ready(1'b0);
        send_frame(8'h77, 1'b1, 1'b0);
        idle(32);
        check("pre_rst_valid", {31'd0, valid}, 32'd1);
        check("pre_rst_data", {24'd0, data}, 32'h77);
        fork
            send_frame(8'h12, 1'b1, 1'b0);
            begin
                repeat (5 * c_bit + 10) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check("rst_mid_valid", {31'd0, valid}, 32'd0);
                check("rst_mid_data", {24'd0, data}, 32'd0);
            end
        join
        idle(c_bit);
        rst = 1'b0;
        idle(c_bit);
        pops0 = pop_cnt;
        set_ready(1'b1);
        send_frame(8'h34, 1'b1, 1'b0);
        idle(64);
        check("post_rst_pops", pop_cnt, pops0 + 1);
        check("post_rst_data", {24'd0, last_pop}, 32'h34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
